alu_exec_ctrl: RTL
==================

# alu_exec_ctrl

Execute-stage sequencer that drives the 8-bit combinational ALU and consumes its result and flags. It accepts one instruction at a time over a valid/ready handshake and holds a 4×8 register file (R0–R3). It registers operands and opcode toward the ALU, captures `resultado`/`flags` into the register file and a flag register, and returns a response with back-pressure. It also evaluates flag-test instructions against the latched flags.

## Interface
- `RESET_FLAGS`, default 8'h00: reset value of the flag register `flags_q`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_valid` in 1: instruction offered.
- `instr` in 17: [16] use_imm, [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm.
- `instr_ready` out 1: high only in IDLE.
- `alu_a` out 8: registered operand A to ALU `A`.
- `alu_b` out 8: registered operand B to ALU `B`.
- `alu_op` out 4: registered opcode to ALU `operacao`.
- `alu_result` in 8: from ALU `resultado`.
- `alu_flags` in 8: from ALU `flags` (N,Z,C,P,I,D,V,- in bits 7..0).
- `res_valid` out 1: response available.
- `res_ready` in 1: downstream accepts the response.
- `res_data` out 8: result value.
- `res_rd` out 2: destination register of the instruction.
- `res_err` out 1: illegal opcode.
- `flags_out` out 8: current `flags_q`.

## Operation
- FSM states: IDLE → EXEC → RESP → IDLE.
- **IDLE:** `instr_ready`=1. On `instr_valid`&&`instr_ready`, latch the instruction and go to EXEC.
  - Set `alu_a` = R[rd].
  - Set `alu_b` = use_imm ? imm : R[rs].
  - Set `alu_op` = op[3:0] for op ≤ 4'b1011; otherwise 4'b0000.
- **EXEC:** one cycle for the ALU to settle. At the closing edge, take the action for the latched op and go to RESP.
  - op 0000–1011 (ALU ops): R[rd] ← `alu_result`; `flags_q` ← `alu_flags`; `res_data` ← `alu_result`.
  - op 1100 (LDI): R[rd] ← imm; `res_data` ← imm; no flag update.
  - op 1101 (TST): cond = `flags_q`[imm[2:0]] ^ imm[3]; `res_data` ← {7'b0, cond}; no register or flag write.
  - op 1110/1111: `res_err` ← 1; `res_data` ← 8'h00; no register or flag write.
- **RESP:** `res_valid`=1. Hold `res_data`, `res_rd` and `res_err` stable until `res_valid`&&`res_ready`, then go to IDLE and clear `res_valid` and `res_err`.
- The register file is written only at the EXEC→RESP edge. A TST evaluates the flags as they stood before its own instruction.
- `alu_a`, `alu_b` and `alu_op` hold their values after EXEC until the next acceptance.
- Width rules: all data is 8-bit. The ALU's carry and multiply truncation are the ALU's concern; this block stores the low 8 bits.

## Timing
- **Reset:** asynchronous, immediate, including mid-EXEC or mid-RESP. Any in-flight instruction is dropped with no response.
  - FSM=IDLE, R0–R3=0, `flags_q`=`RESET_FLAGS`.
  - Outputs: `alu_a`=0, `alu_b`=0, `alu_op`=0, `res_valid`=0, `res_data`=0, `res_rd`=0, `res_err`=0, `instr_ready`=1.
- **Latency:** accept at edge T, EXEC during T+1, `res_valid`=1 from T+2.
  - Best-case throughput: one instruction per 3 cycles.
  - `instr_ready` returns to 1 in the cycle after the response handshake.
- **Same-cycle handshake:** if `res_ready` is already high when `res_valid` rises, the handshake completes in that cycle.
- **Ignored input:** `instr_valid` outside IDLE has no effect.
- **Flag visibility:** `flags_out` reflects the new flags from the first RESP cycle.
- **Read-after-write:** a back-to-back instruction reads the updated register, because the write happens before the next acceptance.

## Test plan
- **Reset:** release `rst_n` with `RESET_FLAGS`=0.
  - Expect `instr_ready`=1, `res_valid`=0, `alu_op`=0, `flags_out`=8'h00.
  - Every response below carries `res_err`=0 unless stated.
- **LDI then ADD with carry to zero:**
  - LDI R1,0x0F (instr=17'h0_C40F) → `res_data`=0x0F, `res_rd`=1 at T+2.
  - Then ADD R1,#0xF1 (instr=17'h1_04F1) → `alu_a`=0x0F, `alu_b`=0xF1, `alu_op`=0, `res_data`=0x00, `flags_out`=8'h60.
  - A following ADD R1,#0x01 returns 0x01, confirming R1=0x00.
- **TST after zero result:**
  - TST imm=0x06 → `res_data`=0x01.
  - TST imm=0x0E → `res_data`=0x00.
  - `flags_out` stays 8'h60 and R1 is unchanged.
- **Back-pressure:**
  - Hold `res_ready`=0 for 5 cycles → `res_valid`=1 with `res_data`/`res_rd` stable; `instr_ready`=0; a second `instr_valid` is not taken.
  - After `res_ready`=1 → `instr_ready`=1 on the next cycle and the second instruction is accepted.
- **Illegal opcode** (op=1110, rd=2):
  - `res_err`=1, `res_data`=0x00, `alu_op`=0.
  - R2 and `flags_out` are unchanged.
  - The next legal instruction returns `res_err`=0.
- **Reset mid-operation:** pull `rst_n` low during EXEC of ADD R0,#0x05.
  - `res_valid`, `alu_a`, `alu_b` and `alu_op` drop to 0 within the same cycle.
  - After release, `instr_ready`=1, no response appears, and reading R0 via ADD R0,#0 returns 0x00.

Source files
------------

// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer for an external 8-bit combinational ALU: accepts one
// instruction at a time, owns a 4x8 register file and flag register, returns a response.
module alu_exec_ctrl #(
  parameter logic [7:0] RESET_FLAGS = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [16:0] instr,
  output logic        instr_ready,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  input  logic [7:0]  alu_result,
  input  logic [7:0]  alu_flags,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data,
  output logic [1:0]  res_rd,
  output logic        res_err,
  output logic [7:0]  flags_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] OP_LAST_ALU = 4'b1011;
  localparam logic [3:0] OP_LDI      = 4'b1100;
  localparam logic [3:0] OP_TST      = 4'b1101;

  logic [1:0] state;
  logic [3:0] op_q;
  logic [1:0] rd_q;
  logic [7:0] imm_q;
  logic [7:0] flags_q;
  logic [7:0] rf [4];

  logic       in_use_imm;
  logic [3:0] in_op;
  logic [1:0] in_rd;
  logic [1:0] in_rs;
  logic [7:0] in_imm;
  logic       accept;

  assign in_use_imm = instr[16];
  assign in_op      = instr[15:12];
  assign in_rd      = instr[11:10];
  assign in_rs      = instr[9:8];
  assign in_imm     = instr[7:0];

  assign instr_ready = (state == ST_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign flags_out   = flags_q;

  logic is_alu_op;
  logic is_ldi;
  logic is_tst;
  logic tst_cond;

  assign is_alu_op = (op_q <= OP_LAST_ALU);
  assign is_ldi    = (op_q == OP_LDI);
  assign is_tst    = (op_q == OP_TST);
  // TST sees flags_q before this instruction: flags_q only changes for ALU ops.
  assign tst_cond  = flags_q[imm_q[2:0]] ^ imm_q[3];

  logic       rf_we;
  logic [7:0] rf_wdata;
  logic [3:0] wr_sel;

  assign rf_we    = (state == ST_EXEC) && (is_alu_op || is_ldi);
  assign rf_wdata = is_ldi ? imm_q : alu_result;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wr_sel
      assign wr_sel[gi] = rf_we && (rd_q == 2'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        rf[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_sel[i]) begin
          rf[i] <= rf_wdata;
        end
      end
    end
  end

  logic [7:0] opnd_a;
  logic [7:0] opnd_b;
  logic [3:0] opnd_op;

  assign opnd_a  = rf[in_rd];
  assign opnd_b  = in_use_imm ? in_imm : rf[in_rs];
  // Non-ALU opcodes present a harmless ADD to the ALU; its result is ignored.
  assign opnd_op = (in_op <= OP_LAST_ALU) ? in_op : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= 4'h0;
      rd_q      <= 2'd0;
      imm_q     <= 8'h00;
      alu_a     <= 8'h00;
      alu_b     <= 8'h00;
      alu_op    <= 4'h0;
      res_valid <= 1'b0;
      res_data  <= 8'h00;
      res_rd    <= 2'd0;
      res_err   <= 1'b0;
      flags_q   <= RESET_FLAGS;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q   <= in_op;
            rd_q   <= in_rd;
            imm_q  <= in_imm;
            alu_a  <= opnd_a;
            alu_b  <= opnd_b;
            alu_op <= opnd_op;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_valid <= 1'b1;
          res_rd    <= rd_q;
          state     <= ST_RESP;
          if (is_alu_op) begin
            res_data <= alu_result;
            res_err  <= 1'b0;
            flags_q  <= alu_flags;
          end else if (is_ldi) begin
            res_data <= imm_q;
            res_err  <= 1'b0;
          end else if (is_tst) begin
            res_data <= {7'b0, tst_cond};
            res_err  <= 1'b0;
          end else begin
            res_data <= 8'h00;
            res_err  <= 1'b1;
          end
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_err   <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
